// File: rtl/act_skew_feeder_if.sv
// Bundle of the activation feeder's input handshake and skewed output bus.
// Statistics signals exist only when ACT_FEED_STATS_EN is defined.
interface act_feed_if #(
   parameter int SIZE  = 8,
   parameter int ACT_W = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    in_last;
   logic [SIZE*ACT_W-1:0]   in_act;
   logic [SIZE*7-1:0]       act_out;
   logic [SIZE-1:0]         row_valid;
   logic                    busy;
   logic                    done;
`ifdef ACT_FEED_STATS_EN
   logic                    stat_clr;
   logic [31:0]             stat_vec_cnt;
   logic [31:0]             stat_stall_cnt;

   modport master (output in_valid, in_last, in_act, stat_clr,
                   input  in_ready, act_out, row_valid, busy, done, stat_vec_cnt, stat_stall_cnt);
   modport slave  (input  in_valid, in_last, in_act, stat_clr,
                   output in_ready, act_out, row_valid, busy, done, stat_vec_cnt, stat_stall_cnt);
`else
   modport master (output in_valid, in_last, in_act,
                   input  in_ready, act_out, row_valid, busy, done);
   modport slave  (input  in_valid, in_last, in_act,
                   output in_ready, act_out, row_valid, busy, done);
`endif
endinterface

// File: rtl/act_skew_feeder.sv
// Diagonal skew feeder for the systolic array's left edge; row r lags row 0 by r cycles.
// Optional ACT_FEED_STATS_EN adds saturating accept/stall counters.
//
// state  | meaning
// IDLE   | no tile in flight, ready for a vector
// STREAM | tile in progress, vectors or bubbles entering
// DRAIN  | last vector accepted, flushing skew pipe until it leaves row SIZE-1
module act_skew_feeder #(
   parameter int SIZE  = 8,
   parameter int ACT_W = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     weight_loading,
   act_feed_if.slave bus
);
   localparam int CW = $clog2(SIZE + 1);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

   state_t          state_q;
   logic [CW-1:0]   drain_cnt_q;
   logic            done_q;
   logic            busy_q;
   logic            adv;
   logic            ready;
   logic            accept;
   logic [SIZE*7-1:0] act_out_w;
   logic [SIZE-1:0]   row_valid_w;

   assign adv    = !weight_loading;
   assign ready  = adv && (state_q != S_DRAIN);
   assign accept = bus.in_valid && ready;

   assign bus.in_ready  = ready;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.act_out   = act_out_w;
   assign bus.row_valid = row_valid_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         drain_cnt_q <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else if (adv) begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_STREAM: begin
               if (accept) begin
                  busy_q <= 1'b1;
                  if (bus.in_last) begin
                     state_q     <= S_DRAIN;
                     drain_cnt_q <= CW'(SIZE);
                     done_q      <= (SIZE == 1);
                  end else begin
                     state_q <= S_STREAM;
                  end
               end
            end
            S_DRAIN: begin
               if (drain_cnt_q == CW'(1)) begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  drain_cnt_q <= '0;
               end else begin
                  drain_cnt_q <= drain_cnt_q - CW'(1);
                  done_q      <= (drain_cnt_q == CW'(2));
               end
            end
            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               drain_cnt_q <= '0;
            end
         endcase
      end
   end

   // Each stage holds {valid, act7}; the upper 7 bits are kept since the array re-appends LSB=1.
   for (genvar r = 0; r < SIZE; r++) begin : g_row
      logic [7:0] pipe_q [0:r];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k <= r; k++) pipe_q[k] <= 8'h00;
         end else if (adv) begin
            pipe_q[0] <= accept ? {1'b1, bus.in_act[r*ACT_W + ACT_W - 1 -: 7]} : 8'h00;
            for (int k = 1; k <= r; k++) pipe_q[k] <= pipe_q[k-1];
         end
      end

      assign act_out_w[7*r +: 7] = pipe_q[r][6:0];
      assign row_valid_w[r]      = pipe_q[r][7];
   end

`ifdef ACT_FEED_STATS_EN
   logic [31:0] stat_vec_q;
   logic [31:0] stat_stall_q;
   logic        stall_evt;

   assign stall_evt = bus.in_valid && !ready;

   // Counters run even while frozen, since stalls are exactly what they observe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_vec_q   <= '0;
         stat_stall_q <= '0;
      end else if (bus.stat_clr) begin
         stat_vec_q   <= '0;
         stat_stall_q <= '0;
      end else begin
         if (accept && (stat_vec_q != 32'hFFFF_FFFF))      stat_vec_q   <= stat_vec_q + 32'd1;
         if (stall_evt && (stat_stall_q != 32'hFFFF_FFFF)) stat_stall_q <= stat_stall_q + 32'd1;
      end
   end

   assign bus.stat_vec_cnt   = stat_vec_q;
   assign bus.stat_stall_cnt = stat_stall_q;
`endif
endmodule

// File: tb/tb_act_skew_feeder.sv
// Randomized bench for act_skew_feeder: history-of-advances reference model, per-scenario tasks.
module tb_act_skew_feeder;
   localparam int SIZE = 4;
   localparam int AW   = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wl = 1'b0;
   always #5 clk = ~clk;

   act_feed_if #(.SIZE(SIZE), .ACT_W(AW)) bus ();
   act_skew_feeder #(.SIZE(SIZE), .ACT_W(AW)) dut (.clk(clk), .rst_n(rst_n), .weight_loading(wl), .bus(bus));

   int n_chk = 0;
   int n_pass = 0;

   // model: one entry per advancing cycle since reset
   bit                    hv [$];
   logic [SIZE*AW-1:0]    ha [$];
   bit                    m_stream;
   int                    last_idx;
   bit                    obs_ready;
   bit                    exp_ready_s;
   logic [6:0]            exp7 [0:SIZE-1];
`ifdef ACT_FEED_STATS_EN
   bit                    stat_clr_b = 1'b0;
   longint                m_vec;
   longint                m_stall;
`endif

   function automatic void m_reset();
      hv.delete();
      ha.delete();
      m_stream = 1'b0;
      last_idx = -1;
`ifdef ACT_FEED_STATS_EN
      m_vec = 0;
      m_stall = 0;
`endif
   endfunction

   function automatic bit m_drain();
      return (last_idx >= 0) && ((hv.size() - last_idx) <= SIZE);
   endfunction

   function automatic bit m_done();
      return (last_idx >= 0) && ((hv.size() - last_idx) == SIZE);
   endfunction

   function automatic bit m_busy();
      return m_stream || m_drain();
   endfunction

   function automatic logic [SIZE*7-1:0] m_act();
      logic [SIZE*7-1:0] v;
      logic [7:0] b;
      int idx;
      int x;
      v = '0;
      for (int r = 0; r < SIZE; r++) begin
         idx = hv.size() - 1 - r;
         if (idx >= 0 && hv[idx]) begin
            b = ha[idx][8*r +: 8];
            x = $signed(b);
            x = x >>> 1;
            v[7*r +: 7] = x[6:0];
         end
      end
      return v;
   endfunction

   function automatic logic [SIZE-1:0] m_rv();
      logic [SIZE-1:0] v;
      int idx;
      v = '0;
      for (int r = 0; r < SIZE; r++) begin
         idx = hv.size() - 1 - r;
         if (idx >= 0) v[r] = hv[idx];
      end
      return v;
   endfunction

   // Drives one cycle of stimulus, samples in_ready, advances the model; returns at posedge+1.
   task automatic cycle(input bit w, input bit v, input bit last, input logic [SIZE*AW-1:0] act);
      bit acc;
      @(negedge clk);
      wl = w;
      bus.in_valid = v;
      bus.in_last = last;
      bus.in_act = act;
`ifdef ACT_FEED_STATS_EN
      bus.stat_clr = stat_clr_b;
`endif
      #1;
      obs_ready = bus.in_ready;
      exp_ready_s = !w && !m_drain();
      @(posedge clk);
      acc = v && exp_ready_s;
`ifdef ACT_FEED_STATS_EN
      if (stat_clr_b) begin
         m_vec = 0;
         m_stall = 0;
      end else begin
         if (acc && m_vec < 64'hFFFF_FFFF) m_vec++;
         if (v && !exp_ready_s && m_stall < 64'hFFFF_FFFF) m_stall++;
      end
`endif
      if (!w) begin
         hv.push_back(acc);
         ha.push_back(acc ? act : '0);
         if (acc) begin
            if (last) begin
               last_idx = hv.size() - 1;
               m_stream = 1'b0;
            end else begin
               m_stream = 1'b1;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      wl = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      bus.in_act = '0;
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      wl = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      bus.in_act = '0;
      m_reset();
      #2;
      n_chk++; if (bus.act_out !== '0) $display("FAIL reset act_out got %h exp 0", bus.act_out); else n_pass++;
      n_chk++; if (bus.row_valid !== '0) $display("FAIL reset row_valid got %b exp 0", bus.row_valid); else n_pass++;
      n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset busy/done got %b/%b exp 0/0", bus.busy, bus.done); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL reset in_ready got %b exp 1", bus.in_ready); else n_pass++;
   endtask

   task automatic test_single_last();
      logic [SIZE*AW-1:0] vec;
      vec = {8'h7F, 8'h80, 8'hFF, 8'h04};
      exp7[0] = 7'h02; exp7[1] = 7'h7F; exp7[2] = 7'h40; exp7[3] = 7'h3F;
      for (int k = 1; k <= SIZE + 3; k++) begin
         if (k == 1) cycle(1'b0, 1'b1, 1'b1, vec);
         else        cycle(1'b0, 1'b0, 1'b0, '0);
         for (int r = 0; r < SIZE; r++) begin
            n_chk++;
            if (bus.row_valid[r] !== (k == r + 1) || (k == r + 1 && bus.act_out[7*r +: 7] !== exp7[r]))
               $display("FAIL single row%0d k%0d got v=%b a=%h exp v=%b a=%h", r, k, bus.row_valid[r], bus.act_out[7*r +: 7], (k == r + 1), exp7[r]);
            else n_pass++;
         end
         n_chk++; if (bus.done !== (k == SIZE)) $display("FAIL single done k%0d got %b exp %b", k, bus.done, (k == SIZE)); else n_pass++;
         n_chk++; if (bus.busy !== (k <= SIZE)) $display("FAIL single busy k%0d got %b exp %b", k, bus.busy, (k <= SIZE)); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [SIZE*AW-1:0] v [0:2];
      for (int i = 0; i < 3; i++) v[i] = {$urandom, $urandom};
      for (int k = 0; k < 3 + SIZE + 2; k++) begin
         if (k < 3) cycle(1'b0, 1'b1, (k == 2), v[k]);
         else       cycle(1'b0, 1'b0, 1'b0, '0);
         n_chk++; if (obs_ready !== exp_ready_s) $display("FAIL b2b in_ready k%0d got %b exp %b", k, obs_ready, exp_ready_s); else n_pass++;
         n_chk++; if (bus.act_out !== m_act()) $display("FAIL b2b act_out k%0d got %h exp %h", k, bus.act_out, m_act()); else n_pass++;
         n_chk++; if (bus.row_valid !== m_rv()) $display("FAIL b2b row_valid k%0d got %b exp %b", k, bus.row_valid, m_rv()); else n_pass++;
         n_chk++; if (bus.done !== m_done() || bus.busy !== m_busy()) $display("FAIL b2b done/busy k%0d got %b/%b exp %b/%b", k, bus.done, bus.busy, m_done(), m_busy()); else n_pass++;
      end
   endtask

   task automatic test_weight_stall();
      for (int k = 0; k < 14 + SIZE; k++) begin
         bit w;
         w = (k >= 2 && k < 7);
         if (k < 9) cycle(w, 1'b1, (k == 8), {$urandom, $urandom});
         else       cycle(1'b0, 1'b0, 1'b0, '0);
         n_chk++; if (obs_ready !== exp_ready_s) $display("FAIL stall in_ready k%0d got %b exp %b", k, obs_ready, exp_ready_s); else n_pass++;
         n_chk++; if (bus.act_out !== m_act()) $display("FAIL stall act_out k%0d got %h exp %h", k, bus.act_out, m_act()); else n_pass++;
         n_chk++; if (bus.row_valid !== m_rv()) $display("FAIL stall row_valid k%0d got %b exp %b", k, bus.row_valid, m_rv()); else n_pass++;
         n_chk++; if (bus.done !== m_done() || bus.busy !== m_busy()) $display("FAIL stall done/busy k%0d got %b/%b exp %b/%b", k, bus.done, bus.busy, m_done(), m_busy()); else n_pass++;
      end
   endtask

   task automatic test_gap();
      logic [SIZE*AW-1:0] v0, v1;
      v0 = {$urandom, $urandom} | {SIZE{8'h02}};
      v1 = {$urandom, $urandom};
      for (int k = 0; k < 3 + SIZE + 2; k++) begin
         if (k == 0)      cycle(1'b0, 1'b1, 1'b0, v0);
         else if (k == 1) cycle(1'b0, 1'b0, 1'b1, v1);
         else if (k == 2) cycle(1'b0, 1'b1, 1'b1, v1);
         else             cycle(1'b0, 1'b0, 1'b0, '0);
         n_chk++; if (obs_ready !== exp_ready_s) $display("FAIL gap in_ready k%0d got %b exp %b", k, obs_ready, exp_ready_s); else n_pass++;
         n_chk++; if (bus.act_out !== m_act()) $display("FAIL gap act_out k%0d got %h exp %h", k, bus.act_out, m_act()); else n_pass++;
         n_chk++; if (bus.row_valid !== m_rv()) $display("FAIL gap row_valid k%0d got %b exp %b", k, bus.row_valid, m_rv()); else n_pass++;
         n_chk++; if (bus.done !== m_done() || bus.busy !== m_busy()) $display("FAIL gap done/busy k%0d got %b/%b exp %b/%b", k, bus.done, bus.busy, m_done(), m_busy()); else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6), ($urandom_range(0, 6) == 0), {$urandom, $urandom});
         n_chk++; if (obs_ready !== exp_ready_s) $display("FAIL rand in_ready k%0d got %b exp %b", k, obs_ready, exp_ready_s); else n_pass++;
         n_chk++; if (bus.act_out !== m_act()) $display("FAIL rand act_out k%0d got %h exp %h", k, bus.act_out, m_act()); else n_pass++;
         n_chk++; if (bus.row_valid !== m_rv()) $display("FAIL rand row_valid k%0d got %b exp %b", k, bus.row_valid, m_rv()); else n_pass++;
         n_chk++; if (bus.done !== m_done() || bus.busy !== m_busy()) $display("FAIL rand done/busy k%0d got %b/%b exp %b/%b", k, bus.done, bus.busy, m_done(), m_busy()); else n_pass++;
      end
   endtask

`ifdef ACT_FEED_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int k = 0; k < 14; k++) cycle((k >= 5 && k < 9), 1'b1, 1'b0, {$urandom, $urandom});
      n_chk++; if (bus.stat_vec_cnt !== 32'd10 || m_vec != 10) $display("FAIL stats vec got %0d exp 10", bus.stat_vec_cnt); else n_pass++;
      n_chk++; if (bus.stat_stall_cnt !== 32'd4 || m_stall != 4) $display("FAIL stats stall got %0d exp 4", bus.stat_stall_cnt); else n_pass++;
      stat_clr_b = 1'b1;
      cycle(1'b0, 1'b1, 1'b0, '0);
      stat_clr_b = 1'b0;
      n_chk++; if (bus.stat_vec_cnt !== 32'd0 || bus.stat_stall_cnt !== 32'd0) $display("FAIL stats clr got %0d/%0d exp 0/0", bus.stat_vec_cnt, bus.stat_stall_cnt); else n_pass++;
      cycle(1'b1, 1'b1, 1'b0, '0);
      n_chk++; if (bus.stat_stall_cnt !== 32'(m_stall)) $display("FAIL stats post-clr stall got %0d exp %0d", bus.stat_stall_cnt, m_stall); else n_pass++;
      do_reset();
   endtask
`endif

   task automatic test_reset_drain();
      cycle(1'b0, 1'b1, 1'b1, {$urandom, $urandom});
      cycle(1'b0, 1'b0, 1'b0, '0);
      n_chk++; if (bus.busy !== 1'b1 || bus.row_valid[1] !== 1'b1) $display("FAIL rdrain pre busy/rv1 got %b/%b exp 1/1", bus.busy, bus.row_valid[1]); else n_pass++;
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      n_chk++; if (bus.act_out !== '0 || bus.row_valid !== '0) $display("FAIL rdrain outputs got %h/%b exp 0/0", bus.act_out, bus.row_valid); else n_pass++;
      n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL rdrain busy/done got %b/%b exp 0/0", bus.busy, bus.done); else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < SIZE + 2; k++) begin
         cycle(1'b0, 1'b0, 1'b0, '0);
         n_chk++; if (obs_ready !== 1'b1) $display("FAIL rdrain in_ready k%0d got %b exp 1", k, obs_ready); else n_pass++;
         n_chk++; if (bus.done !== 1'b0 || bus.row_valid !== '0 || bus.busy !== 1'b0) $display("FAIL rdrain after k%0d got done=%b rv=%b busy=%b exp 0", k, bus.done, bus.row_valid, bus.busy); else n_pass++;
      end
   endtask

   initial begin
`ifdef ACT_FEED_STATS_EN
      bus.stat_clr = 1'b0;
`endif
      test_reset();
      test_single_last();
      test_back_to_back();
      test_weight_stall();
      test_gap();
      test_random();
`ifdef ACT_FEED_STATS_EN
      test_stats();
`endif
      do_reset();
      test_reset_drain();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/act_skew_feeder.md
Name: act_skew_feeder

Overview:
- Upstream neighbour of the RPE systolic array: accepts one vector of SIZE signed 8-bit activations per cycle and emits the diagonally skewed 7-bit activation stream into the left edge of the array.
- Row r is delayed r cycles relative to row 0.
- Each activation is converted to the RPE 7-bit format (upper 7 bits; the array re-appends LSB=1).
- Freezes in lockstep with the array while weights are being loaded, and drains the skew pipe after the last vector of a tile.

Parameters:
- SIZE, 8, number of array rows; also the skew depth.
- ACT_W, 8, input activation width; the output width per row is fixed at 7.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- weight_loading  in  1  array weight-load phase; same signal as the array's Weight_in_valid
- in_valid  in  1  input vector valid
- in_ready  out  1  feeder can accept a vector this cycle
- in_act  in  SIZE*8  row r occupies bits [8r+7:8r], two's complement
- in_last  in  1  qualifies the final vector of a tile; meaningful only with in_valid
- act_out  out  SIZE*7  row r occupies bits [7r+6:7r], feeds RPE Activation_in of array row r
- row_valid  out  SIZE  bit r set when act_out row r carries real data
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when the last vector has left row SIZE-1

Behaviour:
- Reset (async, rst_n=0):
  - act_out=0, row_valid=0, done=0, busy=0, state=IDLE.
  - All skew registers cleared.
  - Reset mid-stream discards in-flight data with no done pulse.
- Clocking: adv = !weight_loading. All skew registers, the FSM and the counter update only when adv=1. When adv=0, everything holds, including outputs, with no bubbles inserted.
- Format conversion: row value = in_act[8r+7:8r+1]. The array value becomes {act7,1}, i.e. a|1.
  - Examples: +4 -> 7'h02 (array sees +5); -1 (8'hFF) -> 7'h7F (array sees -1); -128 -> 7'h40 (array sees -127).
- Accept: in_ready = adv && (state==IDLE || state==STREAM). A vector is accepted when in_valid && in_ready.
- Skew pipe: row r is a chain of r+1 registers holding {valid, act7}.
  - An accepted vector enters stage 0 of every row.
  - When no vector is accepted and adv=1, a bubble enters: valid=0, act7=7'h00.
- Latency: the row r element of a vector accepted at advancing cycle t appears on act_out/row_valid after r+1 advancing cycles.
- Bubble outputs show act7=7'h00 with row_valid=0. Downstream must ignore partial sums derived from them.
- FSM (transitions only when adv=1):
  - IDLE -> STREAM on accept without in_last.
  - IDLE -> DRAIN on accept with in_last.
  - STREAM -> DRAIN on accept with in_last.
  - STREAM holds when in_valid=0; a bubble enters and in_ready stays 1.
  - DRAIN: in_ready=0. drain_cnt loads SIZE on entry and decrements each advancing cycle. At drain_cnt==1, done=1 for that cycle and the next state is IDLE.
- done asserts in the same cycle that row SIZE-1 presents the last vector. When SIZE=1, done coincides with row 0 showing it.
- Simultaneous events:
  - weight_loading=1 with in_valid=1: no accept, because in_ready=0.
  - weight_loading rising in DRAIN pauses drain_cnt; done is deferred accordingly.
- drain_cnt width is $clog2(SIZE+1).

Optional Feature:
- Macro ACT_FEED_STATS_EN.
- When defined, adds outputs stat_vec_cnt (32-bit, counts accepted vectors) and stat_stall_cnt (32-bit, counts cycles with in_valid=1 && in_ready=0).
  - Both saturate at 32'hFFFFFFFF.
  - Both are cleared by rst_n.
  - The extra input stat_clr (1-bit) clears both synchronously. If stat_clr coincides with an increment event, the clear wins.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- SIZE=4, reset, then one in_last vector with rows {+4,-1,-128,+127} -> row r shows {02,7F,40,3F} respectively with row_valid[r]=1 exactly at advancing cycle r+1. done pulses with row 3. busy returns to 0 the next cycle.
- Three back-to-back vectors V0..V2, V2 with in_last -> row 2 shows V0,V1,V2 on cycles 3,4,5. done fires on cycle 6 with row 3 showing V2.
- Assert weight_loading for 5 cycles mid-stream -> all outputs frozen, in_ready=0, and the output sequence after release is identical to the run without the stall, shifted by 5 cycles.
- in_valid gaps in STREAM: pattern V0,gap,V1(last) -> a row_valid=0 bubble appears between V0 and V1 on every row, and act7=00 during the bubble.
- Drop rst_n asynchronously during DRAIN -> outputs clear immediately, no done pulse, IDLE, in_ready=1 after release.
- With ACT_FEED_STATS_EN defined: 10 accepts and 4 stalled-valid cycles -> stat_vec_cnt=10, stat_stall_cnt=4. stat_clr pulse -> both 0.
